alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer that time-shares one `alu_8bit` datapath between `NUM_REQ` thread requesters inside a core. Each request is granted round-robin. The block latches the request's operands and opcode onto the ALU inputs and holds them for an op-dependent number of settle cycles, so the multiplier and divider paths can complete. It then returns the registered result tagged with the requester ID. The ALU instance sits outside this block and connects through the `alu_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `LAT_ADDSUB`, 1: settle cycles for ADD/SUB; must be ≥1.
- `LAT_MUL`, 2: settle cycles for MUL; must be ≥1.
- `LAT_DIV`, 4: settle cycles for DIV; must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer happens when valid & ready.
- `req_rs`  in  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- `req_rt`  in  8*NUM_REQ  operand B; same slicing as `req_rs`.
- `req_op`  in  2*NUM_REQ  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `alu_rs`, `alu_rt`  out  8 each  registered operands driven to the ALU.
- `alu_op`  out  2  registered opcode driven to the ALU.
- `alu_out`  in  8  combinational ALU result.
- `resp_valid`  out  1  single-cycle response pulse.
- `resp_id`  out  $clog2(NUM_REQ)  index of the requester being answered.
- `resp_data`  out  8  result.
- `resp_dz`  out  1  divide-by-zero flag.
- `busy`  out  1  high while in EXEC.

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester, scanning upward from `last_grant+1` modulo NUM_REQ.
  - `req_ready[g]` is combinational and high only in IDLE.
  - At the grant edge, latch `alu_rs/rt/op` and `cur_id`; set `last_grant = g`; load `cnt = LAT(op)-1`; go to EXEC.
- EXEC:
  - `alu_*` stay stable; `req_ready` is all zero.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, capture the result, assert `resp_valid` for the next cycle, and return to IDLE.
- Result rules:
  - `resp_data = alu_out[7:0]`.
  - If `alu_op == DIV` and `alu_rt == 0`, force `resp_data = 8'hFF` and `resp_dz = 1`; otherwise `resp_dz = 0`.
  - Only the low 8 bits of MUL and SUB results are returned; wrap-around is not flagged.
- Response outputs:
  - `resp_id`, `resp_data` and `resp_dz` are valid only while `resp_valid` is high, and hold their values until the next response.
  - There is no response backpressure; requesters must accept the pulse.
- Simultaneous events:
  - A response pulse and a new grant may occur in the same IDLE cycle.
  - Requests arriving during EXEC wait; `req_valid` and the request payload must stay stable until granted.
  - A requester may be re-granted immediately if it is the only one requesting.
- Reset:
  - State IDLE; `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - All outputs are 0.
  - An operation in flight is dropped and no response is produced.

## Timing
- With the grant at edge 0, EXEC covers cycles 1..L and `resp_valid` is high in cycle L+1, where L = LAT(op).
- Issue throughput: one op per L+1 cycles, because the next grant can occur in the same cycle as the response.
- Round-robin guarantees that each requester is granted within NUM_REQ-1 other grants.
- No combinational path from `alu_out` to any output.
- `req_ready` depends combinationally on `req_valid` and state only.

## Structure
Shared package `alu_arb_pkg` contains:
- op codes `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`;
- the state enum `{ST_IDLE, ST_EXEC}`;
- a function mapping an op to its latency from the three parameters.

The natural sub-module is `rr_arbiter`: a purely combinational one-hot grant from the request vector and the `last_grant` pointer, parameterised by N. The FSM, counter and response registers stay in the top module.

## Test plan
- Reset, then requester 2 issues ADD 8'h0F + 8'h01 → `req_ready` = 4'b0100 in that cycle; `resp_valid` 2 cycles later with `resp_id`=2, `resp_data`=8'h10, `resp_dz`=0.
- All 4 requesters hold SUB requests continuously → grant order 0,1,2,3,0, each response LAT_ADDSUB+1 cycles after its grant; SUB 8'h00 − 8'h01 returns 8'hFF.
- MUL 8'h10 × 8'h10 → `resp_data`=8'h00, response 3 cycles after the grant; DIV 8'd100 / 8'd7 → 8'd14, response 5 cycles after the grant.
- DIV 8'd9 / 8'd0 → `resp_data`=8'hFF, `resp_dz`=1, with the normal DIV latency.
- Reset asserted in the middle of a DIV → all outputs 0 immediately; no response is ever produced; after release, requester 0 wins over requester 3 when both request.
- A single requester issues back-to-back requests → each new grant coincides with the previous `resp_valid` cycle, and `alu_*` stay stable throughout every EXEC phase.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU time-sharing sequencer: opcodes, FSM states
// and the per-op settle latency lookup.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    function automatic int op_latency(input logic [1:0] op,
                                      input int lat_addsub,
                                      input int lat_mul,
                                      input int lat_div);
        int lat;
        case (op)
            OP_MUL:  lat = lat_mul;
            OP_DIV:  lat = lat_div;
            default: lat = lat_addsub;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit scanning upward
// from the slot after last_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           any_o
);

    always_comb begin
        int idx;
        logic [IDW-1:0] idx_w;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(last_i) + k) % N;
            idx_w = IDW'(idx);
            if (!any_o && req_i[idx_w]) begin
                any_o        = 1'b1;
                gnt_o[idx_w] = 1'b1;
                gnt_idx_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between NUM_REQ requesters: round-robin grant,
// operand hold for an op-dependent settle time, tagged single-cycle response.
module alu_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LAT_ADDSUB = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [8*NUM_REQ-1:0]       req_rs,
    input  logic [8*NUM_REQ-1:0]       req_rt,
    input  logic [2*NUM_REQ-1:0]       req_op,
    output logic [7:0]                 alu_rs,
    output logic [7:0]                 alu_rt,
    output logic [1:0]                 alu_op,
    input  logic [7:0]                 alu_out,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [7:0]                 resp_data,
    output logic                       resp_dz,
    output logic                       busy
);
    import alu_arb_pkg::*;

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int LAT_MX1 = (LAT_MUL > LAT_ADDSUB) ? LAT_MUL : LAT_ADDSUB;
    localparam int LAT_MAX = (LAT_DIV > LAT_MX1) ? LAT_DIV : LAT_MX1;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    state_e             state_q;
    logic [IDW-1:0]     last_grant_q;
    logic [IDW-1:0]     cur_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         alu_rs_q;
    logic [7:0]         alu_rt_q;
    logic [1:0]         alu_op_q;
    logic               resp_valid_q;
    logic [IDW-1:0]     resp_id_q;
    logic [7:0]         resp_data_q;
    logic               resp_dz_q;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [7:0]         sel_rs;
    logic [7:0]         sel_rt;
    logic [1:0]         sel_op;
    logic [CNT_W-1:0]   cnt_load_d;
    logic               div_zero;
    logic [7:0]         resp_data_d;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr (
        .req_i     (req_valid),
        .last_i    (last_grant_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    always_comb begin
        sel_rs      = req_rs[8*gnt_idx +: 8];
        sel_rt      = req_rt[8*gnt_idx +: 8];
        sel_op      = req_op[2*gnt_idx +: 2];
        // Counter is loaded with LAT-1 so the capture happens in the L-th EXEC cycle.
        cnt_load_d  = CNT_W'(op_latency(sel_op, LAT_ADDSUB, LAT_MUL, LAT_DIV) - 1);
        div_zero    = (alu_op_q == OP_DIV) && (alu_rt_q == 8'h00);
        resp_data_d = div_zero ? 8'hFF : alu_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            cur_id_q     <= '0;
            cnt_q        <= '0;
            alu_rs_q     <= '0;
            alu_rt_q     <= '0;
            alu_op_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_dz_q    <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        alu_rs_q     <= sel_rs;
                        alu_rt_q     <= sel_rt;
                        alu_op_q     <= sel_op;
                        cur_id_q     <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        cnt_q        <= cnt_load_d;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= cur_id_q;
                        resp_data_q  <= resp_data_d;
                        resp_dz_q    <= div_zero;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE) ? gnt_oh : '0;
    assign busy       = (state_q == ST_EXEC);
    assign alu_rs     = alu_rs_q;
    assign alu_rt     = alu_rt_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_dz    = resp_dz_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic checked
// against a timestamp-based reference model with an external ALU model.
module tb_alu_share_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  req_rs;
    logic [31:0]  req_rt;
    logic [7:0]   req_op;
    logic [7:0]   alu_rs;
    logic [7:0]   alu_rt;
    logic [1:0]   alu_op;
    logic [7:0]   alu_out;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [7:0]   resp_data;
    logic         resp_dz;
    logic         busy;

    alu_share_arbiter #(
        .NUM_REQ    (4),
        .LAT_ADDSUB (1),
        .LAT_MUL    (2),
        .LAT_DIV    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_op     (req_op),
        .alu_rs     (alu_rs),
        .alu_rt     (alu_rt),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_dz    (resp_dz),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External ALU; divide by zero returns a junk value the DUT must override.
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = 8'(alu_rs + alu_rt);
            2'b01:   alu_out = 8'(alu_rs - alu_rt);
            2'b10:   alu_out = 8'(alu_rs * alu_rt);
            default: alu_out = (alu_rt == 8'h00) ? 8'h5A : 8'(alu_rs / alu_rt);
        endcase
    end

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
        logic       dz;
    } resp_t;

    resp_t      exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         free_cyc = 0;
    int         last_g = N - 1;
    bit         rand_en = 1'b0;
    bit         pend[N];
    bit         refill[N];
    logic [7:0] p_rs[N];
    logic [7:0] p_rt[N];
    logic [1:0] p_op[N];
    logic [7:0] cur_rs;
    logic [7:0] cur_rt;
    logic [1:0] cur_op;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        if (op == 2'b10) return 2;
        if (op == 2'b11) return 4;
        return 1;
    endfunction

    task automatic ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              output logic [7:0] d, output logic dz);
        int r;
        dz = 1'b0;
        case (op)
            2'b00: r = int'(a) + int'(b);
            2'b01: r = int'(a) - int'(b);
            2'b10: r = int'(a) * int'(b);
            default: begin
                if (b == 8'h00) begin
                    r  = 255;
                    dz = 1'b1;
                end else begin
                    r = int'(a) / int'(b);
                end
            end
        endcase
        d = 8'(r);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = pend[i];
            req_rs[8*i +: 8] = p_rs[i];
            req_rt[8*i +: 8] = p_rt[i];
            req_op[2*i +: 2] = p_op[i];
        end
    endtask

    task automatic post_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        pend[id] = 1'b1;
        p_op[id] = op;
        p_rs[id] = a;
        p_rt[id] = b;
        drive_inputs();
    endtask

    // One clock cycle: compare at the falling edge, advance the model, update stimulus.
    task automatic step();
        int         g;
        int         l;
        logic [3:0] exp_ready;
        logic [7:0] d;
        logic       dz;
        resp_t      r;
        @(negedge clk);
        g = -1;
        if (cyc >= free_cyc) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last_g + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("busy", 32'(busy), 32'(cyc < free_cyc));
        if (cyc < free_cyc) begin
            check_eq("alu_rs_hold", 32'(alu_rs), 32'(cur_rs));
            check_eq("alu_rt_hold", 32'(alu_rt), 32'(cur_rt));
            check_eq("alu_op_hold", 32'(alu_op), 32'(cur_op));
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            check_eq("resp_valid", 32'(resp_valid), 32'd1);
            check_eq("resp_id", 32'(resp_id), 32'(r.id));
            check_eq("resp_data", 32'(resp_data), 32'(r.data));
            check_eq("resp_dz", 32'(resp_dz), 32'(r.dz));
        end else begin
            check_eq("resp_valid_idle", 32'(resp_valid), 32'd0);
        end
        if (g >= 0) begin
            l = lat_of(p_op[g]);
            ref_result(p_op[g], p_rs[g], p_rt[g], d, dz);
            exp_q.push_back('{due: cyc + l + 1, id: g, data: d, dz: dz});
            free_cyc = cyc + l + 1;
            last_g   = g;
            cur_rs   = p_rs[g];
            cur_rt   = p_rt[g];
            cur_op   = p_op[g];
            if (!refill[g]) pend[g] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    post_req(i, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                             ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
                end
            end
        end
        drive_inputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            refill[i] = 1'b0;
        end
        drive_inputs();
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_alu_rs", 32'(alu_rs), 32'd0);
        check_eq("rst_alu_rt", 32'(alu_rt), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_id", 32'(resp_id), 32'd0);
        check_eq("rst_resp_data", 32'(resp_data), 32'd0);
        check_eq("rst_resp_dz", 32'(resp_dz), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        free_cyc = cyc;
        last_g   = N - 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            refill[i] = 1'b0;
            p_rs[i]   = 8'h00;
            p_rt[i]   = 8'h00;
            p_op[i]   = 2'b00;
        end
        drive_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Single ADD from requester 2.
        post_req(2, 2'b00, 8'h0F, 8'h01);
        steps(4);

        // All four hold SUB continuously: rotation 0,1,2,3,0...
        for (int i = 0; i < N; i++) begin
            refill[i] = 1'b1;
            post_req(i, 2'b01, 8'h00, 8'h01);
        end
        steps(11);
        for (int i = 0; i < N; i++) refill[i] = 1'b0;
        steps(12);

        // MUL wrap, DIV, and divide by zero.
        post_req(1, 2'b10, 8'h10, 8'h10);
        steps(5);
        post_req(0, 2'b11, 8'd100, 8'd7);
        steps(7);
        post_req(3, 2'b11, 8'd9, 8'd0);
        steps(7);

        // Reset in the middle of a DIV; nothing may come back from it.
        post_req(1, 2'b11, 8'd50, 8'd5);
        steps(2);
        do_reset();
        steps(6);
        post_req(0, 2'b00, 8'h11, 8'h22);
        post_req(3, 2'b00, 8'h33, 8'h44);
        steps(8);

        // Back-to-back from a single requester.
        refill[3] = 1'b1;
        post_req(3, 2'b10, 8'h07, 8'h09);
        steps(10);
        refill[3] = 1'b0;
        steps(5);

        // Random traffic, then drain.
        rand_en = 1'b1;
        steps(400);
        rand_en = 1'b0;
        steps(40);
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
